// File: rtl/controlador_es_pkg.sv
`default_nettype none
// ============================================================================
// Module   : controlador_es_pkg
// Brief    : Register map, CTRL/PEND bit positions and reset defaults.
// Revision : 1.0 - initial release
// ============================================================================
package controlador_es_pkg;

    localparam logic [3:0] c_off_sal0   = 4'd0;
    localparam logic [3:0] c_off_sal1   = 4'd1;
    localparam logic [3:0] c_off_ent0   = 4'd2;
    localparam logic [3:0] c_off_ent1   = 4'd3;
    localparam logic [3:0] c_off_rld_lo = 4'd4;
    localparam logic [3:0] c_off_rld_hi = 4'd5;
    localparam logic [3:0] c_off_ctrl   = 4'd6;
    localparam logic [3:0] c_off_pend   = 4'd7;

    localparam int c_ctrl_ten      = 0;
    localparam int c_ctrl_mask_lsb = 1;
    localparam int c_ctrl_mask_msb = 3;
    localparam int c_pend_timer    = 0;
    localparam int c_pend_bot_lsb  = 1;

    localparam logic [11:0] c_base_es_rst = 12'hFFF;
    localparam logic [15:0] c_timer_rst   = 16'd999;

endpackage
`default_nettype wire

// File: rtl/sincronizador_flanco.sv
`default_nettype none
// ============================================================================
// Module   : sincronizador_flanco
// Brief    : N-bit 2-flop synchronizer with a rising-edge pulse per bit.
// Revision : 1.0 - initial release
// ============================================================================
module sincronizador_flanco #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync,
    output logic [WIDTH-1:0] o_rise
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;
    logic [WIDTH-1:0] r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
            r_prev <= '0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    // Edge pulse is formed only from flop outputs, so it is glitch-free.
    assign o_sync = r_sync;
    assign o_rise = r_sync & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/controlador_es.sv
`default_nettype none
// ============================================================================
// Module   : controlador_es
// Brief    : CPU I/O controller: output/input ports, reloadable down timer
//            and maskable pending-interrupt register.
// Revision : 1.0 - initial release
// ============================================================================
module controlador_es
    import controlador_es_pkg::*;
#(
    parameter logic [11:0] BASE_ES   = c_base_es_rst,
    parameter logic [15:0] TIMER_RST = c_timer_rst
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [15:0] dir,
    input  logic [7:0]  dato_cpu,
    output logic [7:0]  dato_a_cpu,
    output logic [2:0]  interrupciones,
    input  logic [7:0]  ent_ext0,
    input  logic [7:0]  ent_ext1,
    input  logic [1:0]  botones,
    output logic [7:0]  sal_ext0,
    output logic [7:0]  sal_ext1
);

    logic [7:0]  r_sal0;
    logic [7:0]  r_sal1;
    logic [7:0]  r_reload_lo;
    logic [7:0]  r_reload_hi;
    logic [3:0]  r_ctrl;
    logic [2:0]  r_pend;
    logic [2:0]  r_irq;
    logic [15:0] r_cnt;
    logic        r_load;

    logic [15:0] w_ent_sync;
    logic [15:0] w_ent_rise_unused;
    logic [1:0]  w_bot_sync_unused;
    logic [1:0]  w_bot_rise;
    logic [15:0] w_reload;
    logic [3:0]  w_off;
    logic        w_sel;
    logic        w_wr_hit;
    logic        w_load_req;
    logic        w_expire;
    logic [2:0]  w_pend_set;
    logic [2:0]  w_pend_clr;

    sincronizador_flanco #(.WIDTH(16)) u_sync_ent (
        .clk     (clk),
        .rst_n   (reset),
        .i_async ({ent_ext1, ent_ext0}),
        .o_sync  (w_ent_sync),
        .o_rise  (w_ent_rise_unused)
    );

    sincronizador_flanco #(.WIDTH(2)) u_sync_bot (
        .clk     (clk),
        .rst_n   (reset),
        .i_async (botones),
        .o_sync  (w_bot_sync_unused),
        .o_rise  (w_bot_rise)
    );

    assign w_off    = dir[3:0];
    assign w_sel    = (dir[15:4] == BASE_ES);
    assign w_wr_hit = wr & w_sel;
    assign w_reload = {r_reload_hi, r_reload_lo};

    // A reload write or TEN 0->1 arms a counter load for the next edge.
    assign w_load_req = w_wr_hit &&
                        ((w_off == c_off_rld_lo) || (w_off == c_off_rld_hi) ||
                         ((w_off == c_off_ctrl) && dato_cpu[c_ctrl_ten] && !r_ctrl[c_ctrl_ten]));
    assign w_expire   = r_ctrl[c_ctrl_ten] && !r_load && (r_cnt == 16'd0);
    assign w_pend_clr = (w_wr_hit && (w_off == c_off_pend)) ? dato_cpu[2:0] : 3'b000;

    always_comb begin
        w_pend_set                       = 3'b000;
        w_pend_set[c_pend_timer]         = w_expire;
        w_pend_set[c_pend_bot_lsb +: 2]  = w_bot_rise;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sal0      <= 8'h00;
            r_sal1      <= 8'h00;
            r_reload_lo <= TIMER_RST[7:0];
            r_reload_hi <= TIMER_RST[15:8];
            r_ctrl      <= 4'h0;
        end else if (w_wr_hit) begin
            case (w_off)
                c_off_sal0:   r_sal0      <= dato_cpu;
                c_off_sal1:   r_sal1      <= dato_cpu;
                c_off_rld_lo: r_reload_lo <= dato_cpu;
                c_off_rld_hi: r_reload_hi <= dato_cpu;
                c_off_ctrl:   r_ctrl      <= dato_cpu[3:0];
                default:      ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt  <= TIMER_RST;
            r_load <= 1'b0;
        end else begin
            r_load <= w_load_req;
            if (r_load) begin
                r_cnt <= w_reload;
            end else if (r_ctrl[c_ctrl_ten]) begin
                r_cnt <= (r_cnt == 16'd0) ? w_reload : r_cnt - 16'd1;
            end
        end
    end

    // Set is OR-ed after the clear so a same-edge event wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pend <= 3'b000;
            r_irq  <= 3'b000;
        end else begin
            r_pend <= (r_pend & ~w_pend_clr) | w_pend_set;
            r_irq  <= r_pend & r_ctrl[c_ctrl_mask_msb:c_ctrl_mask_lsb];
        end
    end

    always_comb begin
        dato_a_cpu = 8'h00;
        if (rd && w_sel) begin
            case (w_off)
                c_off_sal0:   dato_a_cpu = r_sal0;
                c_off_sal1:   dato_a_cpu = r_sal1;
                c_off_ent0:   dato_a_cpu = w_ent_sync[7:0];
                c_off_ent1:   dato_a_cpu = w_ent_sync[15:8];
                c_off_rld_lo: dato_a_cpu = r_reload_lo;
                c_off_rld_hi: dato_a_cpu = r_reload_hi;
                c_off_ctrl:   dato_a_cpu = {4'h0, r_ctrl};
                c_off_pend:   dato_a_cpu = {5'b00000, r_pend};
                default:      dato_a_cpu = 8'h00;
            endcase
        end
    end

    assign sal_ext0       = r_sal0;
    assign sal_ext1       = r_sal1;
    assign interrupciones = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_controlador_es.sv
`default_nettype none
// ============================================================================
// Module   : tb_controlador_es
// Brief    : Self-checking bench: vector table, directed timer/interrupt
//            sequences and randomized traffic against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_controlador_es;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd, wr;
    logic [15:0] dir;
    logic [7:0]  dato_cpu;
    logic [7:0]  dato_a_cpu;
    logic [2:0]  interrupciones;
    logic [7:0]  ent_ext0, ent_ext1;
    logic [1:0]  botones;
    logic [7:0]  sal_ext0, sal_ext1;

    int total = 0;
    int bad   = 0;

    controlador_es dut (
        .clk            (clk),
        .reset          (reset),
        .rd             (rd),
        .wr             (wr),
        .dir            (dir),
        .dato_cpu       (dato_cpu),
        .dato_a_cpu     (dato_a_cpu),
        .interrupciones (interrupciones),
        .ent_ext0       (ent_ext0),
        .ent_ext1       (ent_ext1),
        .botones        (botones),
        .sal_ext0       (sal_ext0),
        .sal_ext1       (sal_ext1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] dir;
        logic [7:0]  data;
        logic        chk;
        logic [7:0]  exp_rd;
        logic [7:0]  exp_s0;
    } vec_t;

    vec_t vt[21];

    // Reference model state
    logic [7:0]  m_sal0, m_sal1, m_lo, m_hi;
    logic [3:0]  m_ctrl;
    logic [2:0]  m_pend, m_irq;
    logic        m_load;
    int          m_n, m_last, m_per;
    logic [1:0]  m_bh1, m_bh2, m_bh3;
    logic [15:0] m_eh1, m_eh2;

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        wr = 1'b1; dir = a; dato_cpu = d;
        tick();
        wr = 1'b0;
    endtask

    task automatic read_chk(input logic [15:0] a, input logic [7:0] e, input string nm);
        rd = 1'b1; dir = a;
        #2;
        check(nm, {8'h00, dato_a_cpu}, {8'h00, e});
        rd = 1'b0;
    endtask

    task automatic model_reset();
        m_sal0 = 8'h00; m_sal1 = 8'h00; m_lo = 8'hE7; m_hi = 8'h03;
        m_ctrl = 4'h0; m_pend = 3'b000; m_irq = 3'b000; m_load = 1'b0;
        m_n = 0; m_last = 0; m_per = 1000;
        m_bh1 = 2'b00; m_bh2 = 2'b00; m_bh3 = 2'b00;
        m_eh1 = 16'h0000; m_eh2 = 16'h0000;
    endtask

    function automatic logic [7:0] model_read();
        logic [7:0] v;
        v = 8'h00;
        if (rd && dir[15:4] == 12'hFFF) begin
            case (dir[3:0])
                4'd0: v = m_sal0;
                4'd1: v = m_sal1;
                4'd2: v = m_eh2[7:0];
                4'd3: v = m_eh2[15:8];
                4'd4: v = m_lo;
                4'd5: v = m_hi;
                4'd6: v = {4'h0, m_ctrl};
                4'd7: v = {5'b00000, m_pend};
                default: v = 8'h00;
            endcase
        end
        return v;
    endfunction

    // Timer seen as an arithmetic schedule: expiries every (reload+1) edges
    // after the most recent load, while enabled.
    task automatic model_edge();
        logic       we, expire;
        logic [3:0] off;
        logic [2:0] clr;
        off = dir[3:0];
        we  = wr && (dir[15:4] == 12'hFFF);
        expire = 1'b0;
        if (m_load) begin
            m_last = m_n;
            m_per  = int'({m_hi, m_lo}) + 1;
        end else if (m_ctrl[0] && m_n > m_last && ((m_n - m_last) % m_per) == 0) begin
            expire = 1'b1;
        end
        m_load = we && (off == 4'd4 || off == 4'd5 || (off == 4'd6 && dato_cpu[0] && !m_ctrl[0]));
        clr    = (we && off == 4'd7) ? dato_cpu[2:0] : 3'b000;
        m_irq  = m_pend & m_ctrl[3:1];
        m_pend = (m_pend & ~clr) | {m_bh2 & ~m_bh3, expire};
        if (we) begin
            case (off)
                4'd0: m_sal0 = dato_cpu;
                4'd1: m_sal1 = dato_cpu;
                4'd4: m_lo   = dato_cpu;
                4'd5: m_hi   = dato_cpu;
                4'd6: m_ctrl = dato_cpu[3:0];
                default: ;
            endcase
        end
        m_bh3 = m_bh2; m_bh2 = m_bh1; m_bh1 = botones;
        m_eh2 = m_eh1; m_eh1 = {ent_ext1, ent_ext0};
        m_n++;
    endtask

    initial begin
        reset = 1'b0; rd = 1'b0; wr = 1'b0; dir = 16'h0000; dato_cpu = 8'h00;
        ent_ext0 = 8'h00; ent_ext1 = 8'h00; botones = 2'b00;

        //                rd    wr    dir       data   chk   exp_rd exp_s0
        vt[0]  = '{1'b0, 1'b1, 16'hFFF0, 8'hA5, 1'b0, 8'h00, 8'h00};
        vt[1]  = '{1'b1, 1'b0, 16'hFFF0, 8'h00, 1'b1, 8'hA5, 8'hA5};
        vt[2]  = '{1'b0, 1'b1, 16'hFFF1, 8'h5A, 1'b0, 8'h00, 8'hA5};
        vt[3]  = '{1'b1, 1'b0, 16'hFFF1, 8'h00, 1'b1, 8'h5A, 8'hA5};
        vt[4]  = '{1'b0, 1'b1, 16'hFFF4, 8'h34, 1'b0, 8'h00, 8'hA5};
        vt[5]  = '{1'b0, 1'b1, 16'hFFF5, 8'h12, 1'b0, 8'h00, 8'hA5};
        vt[6]  = '{1'b1, 1'b0, 16'hFFF4, 8'h00, 1'b1, 8'h34, 8'hA5};
        vt[7]  = '{1'b1, 1'b0, 16'hFFF5, 8'h00, 1'b1, 8'h12, 8'hA5};
        vt[8]  = '{1'b0, 1'b1, 16'hFFF6, 8'hF1, 1'b0, 8'h00, 8'hA5};
        vt[9]  = '{1'b1, 1'b0, 16'hFFF6, 8'h00, 1'b1, 8'h01, 8'hA5};
        vt[10] = '{1'b0, 1'b1, 16'hFFF6, 8'h00, 1'b0, 8'h00, 8'hA5};
        vt[11] = '{1'b1, 1'b0, 16'hFFF9, 8'h00, 1'b1, 8'h00, 8'hA5};
        vt[12] = '{1'b0, 1'b1, 16'hFFF9, 8'hFF, 1'b0, 8'h00, 8'hA5};
        vt[13] = '{1'b1, 1'b0, 16'hFFF9, 8'h00, 1'b1, 8'h00, 8'hA5};
        vt[14] = '{1'b0, 1'b1, 16'hFFF2, 8'h77, 1'b0, 8'h00, 8'hA5};
        vt[15] = '{1'b1, 1'b0, 16'hFFF2, 8'h00, 1'b1, 8'h00, 8'hA5};
        vt[16] = '{1'b1, 1'b0, 16'hEFF0, 8'h00, 1'b1, 8'h00, 8'hA5};
        vt[17] = '{1'b0, 1'b0, 16'hFFF0, 8'h00, 1'b1, 8'h00, 8'hA5};
        vt[18] = '{1'b1, 1'b1, 16'hFFF0, 8'h11, 1'b1, 8'hA5, 8'hA5};
        vt[19] = '{1'b1, 1'b0, 16'hFFF0, 8'h00, 1'b1, 8'h11, 8'h11};
        vt[20] = '{1'b1, 1'b0, 16'hFFF7, 8'h00, 1'b1, 8'h00, 8'h11};

        repeat (2) tick();
        reset = 1'b1;

        // Reset state
        check("rst_sal0", {8'h00, sal_ext0}, 16'h0000);
        check("rst_sal1", {8'h00, sal_ext1}, 16'h0000);
        check("rst_irq", {13'h0, interrupciones}, 16'h0000);
        check("rst_rd_idle", {8'h00, dato_a_cpu}, 16'h0000);
        read_chk(16'hFFF4, 8'hE7, "rst_reload_lo");
        read_chk(16'hFFF5, 8'h03, "rst_reload_hi");
        read_chk(16'hFFF6, 8'h00, "rst_ctrl");

        for (int i = 0; i < 21; i++) begin
            rd = vt[i].rd; wr = vt[i].wr; dir = vt[i].dir; dato_cpu = vt[i].data;
            #2;
            if (vt[i].chk) check($sformatf("vec%0d_rd", i), {8'h00, dato_a_cpu}, {8'h00, vt[i].exp_rd});
            check($sformatf("vec%0d_sal0", i), {8'h00, sal_ext0}, {8'h00, vt[i].exp_s0});
            tick();
            rd = 1'b0; wr = 1'b0;
        end

        // Input synchronizer latency
        ent_ext1 = 8'h3C;
        tick();
        read_chk(16'hFFF3, 8'h00, "ent1_lat1");
        tick();
        read_chk(16'hFFF3, 8'h3C, "ent1_lat2");
        cpu_write(16'hFFF3, 8'h55);
        read_chk(16'hFFF3, 8'h3C, "ent1_ro");

        // Timer period 5 with TEN and mask bit 0
        cpu_write(16'hFFF4, 8'h04);
        cpu_write(16'hFFF5, 8'h00);
        cpu_write(16'hFFF7, 8'h07);
        cpu_write(16'hFFF6, 8'h03);
        repeat (5) tick();
        read_chk(16'hFFF7, 8'h00, "tmr_before");
        tick();
        read_chk(16'hFFF7, 8'h01, "tmr_expire");
        check("tmr_irq_lag", {13'h0, interrupciones}, 16'h0000);
        tick();
        check("tmr_irq", {13'h0, interrupciones}, 16'h0001);
        cpu_write(16'hFFF7, 8'h01);
        read_chk(16'hFFF7, 8'h00, "tmr_w1c");
        tick();
        check("tmr_irq_drop", {13'h0, interrupciones}, 16'h0000);
        tick();
        read_chk(16'hFFF7, 8'h00, "tmr_period_pre");
        tick();
        read_chk(16'hFFF7, 8'h01, "tmr_period");
        repeat (4) tick();
        cpu_write(16'hFFF7, 8'h01);
        read_chk(16'hFFF7, 8'h01, "set_wins_clr");

        // Button edge with masked interrupt
        cpu_write(16'hFFF6, 8'h00);
        cpu_write(16'hFFF7, 8'h07);
        botones = 2'b10;
        repeat (3) tick();
        botones = 2'b00;
        tick();
        read_chk(16'hFFF7, 8'h04, "bot1_pend");
        check("bot1_masked", {13'h0, interrupciones}, 16'h0000);
        cpu_write(16'hFFF6, 8'h08);
        tick();
        check("bot1_irq", {13'h0, interrupciones}, 16'h0004);

        // Reload 0: expiry every cycle
        cpu_write(16'hFFF4, 8'h00);
        cpu_write(16'hFFF6, 8'h09);
        repeat (2) tick();
        for (int k = 0; k < 4; k++) begin
            cpu_write(16'hFFF7, 8'h01);
            read_chk(16'hFFF7, 8'h05, $sformatf("rld0_cyc%0d", k));
        end

        // Reset mid-count with all interrupts pending
        cpu_write(16'hFFF0, 8'hFF);
        cpu_write(16'hFFF1, 8'hC3);
        cpu_write(16'hFFF6, 8'h0F);
        botones = 2'b11;
        repeat (3) tick();
        botones = 2'b00;
        repeat (2) tick();
        read_chk(16'hFFF7, 8'h07, "pend_all");
        tick();
        check("irq_all", {13'h0, interrupciones}, 16'h0007);
        #3 reset = 1'b0;
        #1;
        check("async_rst_sal0", {8'h00, sal_ext0}, 16'h0000);
        check("async_rst_sal1", {8'h00, sal_ext1}, 16'h0000);
        check("async_rst_irq", {13'h0, interrupciones}, 16'h0000);
        check("async_rst_rd", {8'h00, dato_a_cpu}, 16'h0000);
        tick();
        reset = 1'b1;
        check("rst_cnt", dut.r_cnt, 16'd999);
        read_chk(16'hFFF6, 8'h00, "rst_ten");
        read_chk(16'hFFF7, 8'h00, "rst_pend");
        read_chk(16'hFFF5, 8'h03, "rst_reload_hi2");
        repeat (3) tick();
        check("rst_irq_stays", {13'h0, interrupciones}, 16'h0000);

        // Randomized traffic against the reference model
        ent_ext0 = 8'h00; ent_ext1 = 8'h00; botones = 2'b00;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        model_reset();
        for (int c = 0; c < 600; c++) begin
            logic [3:0] off;
            off      = 4'($urandom_range(0, 15));
            rd       = 1'($urandom_range(0, 1));
            wr       = ($urandom_range(0, 3) == 0);
            dir      = {(($urandom_range(0, 7) == 0) ? 12'hABC : 12'hFFF), off};
            dato_cpu = (off == 4'd5) ? 8'h00 : (off == 4'd4) ? 8'($urandom_range(0, 7)) : 8'($urandom);
            ent_ext0 = 8'($urandom);
            ent_ext1 = 8'($urandom);
            if ($urandom_range(0, 3) == 0) botones = 2'($urandom);
            #2;
            check("rnd_rd", {8'h00, dato_a_cpu}, {8'h00, model_read()});
            check("rnd_sal0", {8'h00, sal_ext0}, {8'h00, m_sal0});
            check("rnd_sal1", {8'h00, sal_ext1}, {8'h00, m_sal1});
            check("rnd_irq", {13'h0, interrupciones}, {13'h0, m_irq});
            tick();
            model_edge();
        end
        rd = 1'b0; wr = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/controlador_es.md
CONTROLADOR_ES -- requirements
Module: controlador_es

Interface
REQ-001 The block SHALL have parameter BASE_ES, default 12'hFFF, meaning the I/O window selected when dir[15:4] equals it.
REQ-002 The block SHALL have parameter TIMER_RST, default 16'd999, meaning the reload value after reset.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, the reset: asynchronous, active-low.
REQ-005 The block SHALL have port rd, input, 1, the CPU read strobe.
REQ-006 The block SHALL have port wr, input, 1, the CPU write strobe.
REQ-007 The block SHALL have port dir, input, 16, the CPU address.
REQ-008 The block SHALL have port dato_cpu, input, 8, the CPU write data (CPU salidaDispositivo).
REQ-009 The block SHALL have port dato_a_cpu, output, 8, the read data to CPU (CPU entradaDispositivo).
REQ-010 The block SHALL have port interrupciones, output, 3, the interrupt lines to CPU.
REQ-011 The block SHALL have port ent_ext0 and ent_ext1, input, 8 each, the asynchronous external input ports.
REQ-012 The block SHALL have port botones, input, 2, the asynchronous external event lines.
REQ-013 The block SHALL have port sal_ext0 and sal_ext1, output, 8 each, the external output ports.

Function
REQ-014 The block SHALL select a register when dir[15:4]==BASE_ES; offset dir[3:0]: 0 SAL0 rw, 1 SAL1 rw, 2 ENT0 ro, 3 ENT1 ro, 4 RELOAD_LO rw, 5 RELOAD_HI rw, 6 CTRL rw, 7 PEND read/write-1-to-clear, 8-F read 0 and ignore writes.
REQ-015 The block SHALL perform writes on the clk edge where wr=1 and the register is selected; read-only offsets SHALL ignore writes.
REQ-016 dato_a_cpu SHALL be combinational: the selected register when rd=1, else 8'h00; when rd=1 and wr=1 together, it SHALL show the pre-write value while the write completes.
REQ-017 sal_ext0 and sal_ext1 SHALL be driven directly from SAL0 and SAL1.
REQ-018 ent_ext0 and ent_ext1 and botones SHALL each pass through a 2-flop synchronizer; ENT0 and ENT1 read the synchronized values (2-cycle latency).
REQ-019 CTRL bit0 SHALL be the timer enable (TEN); CTRL bits[3:1] SHALL be the interrupt mask for PEND[2:0]; CTRL bits[7:4] SHALL read 0.
REQ-020 The timer SHALL be a 16-bit down counter, CNT; while TEN=1 it decrements each cycle, and when CNT==0 it SHALL reload from {RELOAD_HI,RELOAD_LO} and set PEND[0], giving a period of reload+1 cycles.
REQ-021 Writing RELOAD_LO or RELOAD_HI, or a TEN 0->1 transition, SHALL load CNT with the new reload value on the following edge; CNT SHALL hold while TEN=0.
REQ-022 A rising edge on synchronized botones[i] SHALL set PEND[i+1] one cycle after the synchronizer output rises.
REQ-023 A PEND bit SHALL stay set until the CPU writes 1 to it; writing 0 SHALL have no effect; if a set event and a clear occur on the same edge, set SHALL win.
REQ-024 interrupciones SHALL be registered as PEND & CTRL[3:1], one cycle after PEND changes.
REQ-025 With reload=0 and TEN=1, PEND[0] SHALL be set every cycle without stalling the counter.

Reset
REQ-026 On reset=0, regardless of clk, all of the following SHALL be 0: SAL0, SAL1, CTRL, PEND, interrupciones, synchronizer and edge flops.
REQ-027 On reset=0, {RELOAD_HI,RELOAD_LO} and CNT SHALL be set to TIMER_RST.
REQ-028 Outputs after reset: sal_ext0=sal_ext1=8'h00, interrupciones=3'b000, dato_a_cpu=8'h00 unless rd=1.
REQ-029 Reset asserted mid-timer-period or with interrupts pending SHALL discard all state; no interrupt SHALL survive reset.

Structure
REQ-030 A shared package SHALL hold the register offset constants (0-7), the CTRL/PEND bit positions, and the reset defaults.
REQ-031 A sub-module sincronizador_flanco SHALL be used: a parameterizable-width 2-flop synchronizer with a registered rising-edge pulse output, instantiated for botones (edge used) and ent_ext (level used).

Verification
REQ-032 Directed test: write 8'hA5 to FFF0, then read FFF0 -> sal_ext0=8'hA5 the next cycle and dato_a_cpu=8'hA5 during rd.
REQ-033 Directed test: set ent_ext1=8'h3C, wait 3 cycles, read FFF3 -> 8'h3C; read FFF9 -> 8'h00; a write to FFF2 leaves the register unchanged.
REQ-034 Directed test: RELOAD=16'd4, CTRL=8'h03 -> PEND[0] set every 5 cycles and interrupciones[0]=1 one cycle after; write 8'h01 to FFF7 -> interrupciones[0] drops the cycle after.
REQ-035 Directed test: pulse botones[1] high for 3 cycles with mask bit 3 = 0 -> PEND=3'b100 and interrupciones=0; then set CTRL=8'h08 -> interrupciones[2]=1.
REQ-036 Directed test: a timer expiry on the same edge as a W1C of PEND[0] -> PEND[0] remains 1.
REQ-037 Directed test: assert reset mid-count with PEND=3'b111 -> all outputs 0 immediately; after release, CNT=999 and TEN=0.
